kamus_lsu_ctrl: RTL and testbench
=================================

# kamus_lsu_ctrl

Sequencing controller for the kamus load/store datapath. Accepts one load or store per handshake from the execute stage and drives a single-outstanding request/grant/response data-memory port. Generates byte enables and lane-replicated store data, and sign/zero-extends load data for register writeback. Reports misaligned, bus-error and timeout exceptions to the trap logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ+WAIT before access fault; 0 disables timeout.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- lsu_valid_i  in  1  request valid from execute stage.
- lsu_ready_o  out  1  high only in IDLE.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_width_i  in  2  mem_width_t (B/H/W).
- lsu_unsigned_i  in  1  zero-extend load (LBU/LHU).
- lsu_addr_i  in  32  effective byte address.
- lsu_wdata_i  in  32  store data from register file.
- lsu_rd_i  in  5  load destination register.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-replicated store data.
- data_rvalid_i  in  1  response valid (loads and stores).
- data_rdata_i  in  32  load data.
- data_err_i  in  1  bus error, qualified by data_rvalid_i.
- wb_valid_o  out  1  one-cycle load writeback pulse.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  32  extended load data.
- exc_valid_o  out  1  one-cycle exception pulse.
- exc_cause_o  out  2  lsu_exc_t: LD_MISALIGN, ST_MISALIGN, LD_FAULT, ST_FAULT.
- exc_addr_o  out  32  faulting byte address (original lsu_addr_i).
- busy_o  out  1  state != IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on lsu_valid_i & lsu_ready_o, register we/width/unsigned/addr/wdata/rd.
    - If aligned -> REQ.
    - If misaligned -> stay IDLE and pulse exc (no memory access).
  - REQ: data_req_o=1, with addr/we/be/wdata held stable until grant. On data_gnt_i -> WAIT.
  - WAIT: on data_rvalid_i -> IDLE.
    - data_err_i=1: exc pulse, LD_FAULT or ST_FAULT.
    - Load with no error: wb pulse.
    - Store with no error: no output pulse.
- Misaligned: H with addr[0]=1; W with addr[1:0]!=0. Width 2'b11 is treated as W.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
- Store data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- Load data:
  - Select byte/half at offset addr[1:0] from data_rdata_i.
  - Sign-extend unless unsigned; W passes through.
- Timeout counter:
  - Cleared on accept; increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT_CYCLES (nonzero) -> access-fault exc and return to IDLE.
  - A data_rvalid_i arriving in IDLE is ignored.
- Reset values: state IDLE, counter 0, lsu_ready_o=1, data_req_o=0, wb_valid_o=0, exc_valid_o=0, busy_o=0, all data/addr/rd outputs 0.
- Reset mid-operation abandons the access; data_req_o drops in the next cycle.

## Timing
- Accept at edge N. data_req_o rises in cycle N+1.
- Grant in N+1 -> WAIT from N+2.
- rvalid in cycle M -> wb_valid_o/exc_valid_o (registered) in cycle M+1. Minimum load latency: accept-to-wb_valid is 3 cycles.
- Misaligned accept at N -> exc_valid_o in cycle N+1.
- lsu_ready_o is combinational from state. A new request may be accepted in the same cycle as a wb or exc pulse.
- Grant and rvalid in the same cycle: grant takes effect; rvalid is only sampled in WAIT.
- Timeout has priority over a coincident rvalid in the same cycle.

## Structure
- kamus_pkg:
  - mem_width_t (B=2'b00, H=2'b01, W=2'b10).
  - lsu_state_t.
  - lsu_exc_t.
- Sub-module kamus_lsu_align, purely combinational:
  - Misalignment check.
  - Byte-enable, store-lane and load-extract/extend logic.
  - Instantiated once in kamus_lsu_ctrl.

## Test plan
- LB at 0x1003; rdata 0x80AA_BBCC, grant and rvalid at earliest -> data_be_o=4'b1000, data_addr_o=0x1000; wb_data_o=0xFFFF_FF80 three cycles after accept. Repeat as LBU -> 0x0000_0080.
- SH at 0x2002, wdata 0x1234_5678; grant delayed 4 cycles -> req/addr/be=4'b1100/wdata=0x5678_5678 stable until grant; no wb pulse.
- LW at 0x3001 -> no data_req_o; exc_valid_o=1 with LD_MISALIGN, exc_addr_o=0x3001, in cycle N+1. SW at 0x3002 -> ST_MISALIGN.
- LW with rvalid and data_err_i=1 -> LD_FAULT pulse, no wb. TIMEOUT_CYCLES=8 with grant never given -> LD_FAULT after 8 busy cycles; a later rvalid is ignored.
- Back-to-back: new request held valid during wb pulse -> accepted that cycle. rst_ni low while in WAIT -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types for the kamus load/store unit: access widths, controller
// states, exception causes and a couple of small address helpers.
package kamus_pkg;

    // Access width as encoded by the execute stage; 2'b11 is handled as a word.
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_width_t;

    // Sequencing states of the single-outstanding memory port.
    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_t;

    // Exception causes reported to the trap logic.
    typedef enum logic [1:0] {
        EXC_LD_MISALIGN = 2'd0,
        EXC_ST_MISALIGN = 2'd1,
        EXC_LD_FAULT    = 2'd2,
        EXC_ST_FAULT    = 2'd3
    } lsu_exc_t;

    localparam int XLEN = 32;

    // Word address presented on the memory port.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // Cause for an alignment problem detected at accept time.
    function automatic lsu_exc_t misalign_cause(input logic we);
        return we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    endfunction

    // Cause for a bus error or a timed-out access.
    function automatic lsu_exc_t fault_cause(input logic we);
        return we ? EXC_ST_FAULT : EXC_LD_FAULT;
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store lane
// replication and load byte/half extraction with sign or zero extension.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_misalign,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;
    logic        w_sign_b;
    logic        w_sign_h;

    // Bring the addressed byte/half down to bit 0 of the load word.
    assign w_shift  = i_rdata >> {i_offset, 3'b000};
    assign w_sign_b = ~i_unsigned & w_shift[7];
    assign w_sign_h = ~i_unsigned & w_shift[15];

    // Width-dependent lane selection; anything that is not B or H is a word.
    always_comb begin
        o_misalign = 1'b0;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        case (i_width)
            MEM_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sign_b}}, w_shift[7:0]};
            end
            MEM_H: begin
                o_misalign = i_offset[0];
                o_be       = 4'b0011 << i_offset;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_sign_h}}, w_shift[15:0]};
            end
            default: begin
                o_misalign = |i_offset;
            end
        endcase
    end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencing controller: accepts one access from execute, runs it
// over a request/grant/response memory port with one access outstanding,
// and reports writebacks and exceptions as registered one-cycle pulses.
module kamus_lsu_ctrl
    import kamus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_width_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  lsu_rd_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_valid_o,
    output logic [1:0]  exc_cause_o,
    output logic [31:0] exc_addr_o,
    output logic        busy_o
);

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;

    logic        r_we;
    logic [1:0]  r_width;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [31:0] r_cnt;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_exc_valid;
    lsu_exc_t    r_exc_cause;
    logic [31:0] r_exc_addr;

    logic        w_idle;
    logic        w_busy;
    logic        w_accept;
    logic        w_misalign_acc;
    logic        w_timeout;
    logic        w_resp;
    logic        w_resp_err;
    logic        w_resp_load;
    logic [31:0] w_cnt_inc;

    logic [1:0]  w_al_width;
    logic [1:0]  w_al_offset;
    logic        w_al_misalign;
    logic [3:0]  w_al_be;
    logic [31:0] w_al_wdata;
    logic [31:0] w_al_rdata;

    assign w_idle = (r_state == LSU_IDLE);
    assign w_busy = ~w_idle;

    // The alignment check only matters in IDLE, where it looks at the live
    // request; afterwards the same lanes serve the captured access.
    assign w_al_width  = w_idle ? lsu_width_i      : r_width;
    assign w_al_offset = w_idle ? lsu_addr_i[1:0]  : r_addr[1:0];

    kamus_lsu_align u_align (
        .i_width    (w_al_width),
        .i_unsigned (r_unsigned),
        .i_offset   (w_al_offset),
        .i_wdata    (r_wdata),
        .i_rdata    (data_rdata_i),
        .o_misalign (w_al_misalign),
        .o_be       (w_al_be),
        .o_wdata    (w_al_wdata),
        .o_rdata    (w_al_rdata)
    );

    assign w_accept       = lsu_valid_i & w_idle;
    assign w_misalign_acc = w_accept & w_al_misalign;

    // The counter holds the number of busy cycles already completed, so the
    // limit is reached at the end of the TIMEOUT_CYCLES-th busy cycle.
    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_timeout = w_busy & (TO_LIMIT != 32'd0) & (w_cnt_inc == TO_LIMIT);

    // A response only counts in WAIT, and a coincident timeout wins.
    assign w_resp      = (r_state == LSU_WAIT) & data_rvalid_i & ~w_timeout;
    assign w_resp_err  = w_resp & data_err_i;
    assign w_resp_load = w_resp & ~data_err_i & ~r_we;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept && !w_al_misalign) begin
                    w_state_next = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (w_timeout) begin
                    w_state_next = LSU_IDLE;
                end else if (data_gnt_i) begin
                    w_state_next = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (w_timeout || data_rvalid_i) begin
                    w_state_next = LSU_IDLE;
                end
            end
            default: begin
                w_state_next = LSU_IDLE;
            end
        endcase
    end

    // Port outputs decoded from state; request fields are quiet outside REQ.
    always_comb begin
        lsu_ready_o  = w_idle;
        busy_o       = w_busy;
        data_req_o   = 1'b0;
        data_addr_o  = 32'd0;
        data_we_o    = 1'b0;
        data_be_o    = 4'd0;
        data_wdata_o = 32'd0;
        if (r_state == LSU_REQ) begin
            data_req_o   = 1'b1;
            data_addr_o  = word_addr(r_addr);
            data_we_o    = r_we;
            data_be_o    = w_al_be;
            data_wdata_o = w_al_wdata;
        end
    end

    // Capture the access on accept so the execute stage can move on.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_we       <= 1'b0;
            r_width    <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
        end else if (w_accept) begin
            r_we       <= lsu_we_i;
            r_width    <= lsu_width_i;
            r_unsigned <= lsu_unsigned_i;
            r_addr     <= lsu_addr_i;
            r_wdata    <= lsu_wdata_i;
            r_rd       <= lsu_rd_i;
        end
    end

    // Busy-cycle counter for the access timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= 32'd0;
        end else if (w_accept) begin
            r_cnt <= 32'd0;
        end else if (w_busy) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Registered load writeback pulse with its payload.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_wb_valid <= w_resp_load;
            if (w_resp_load) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_al_rdata;
            end
        end
    end

    // Registered exception pulse: misalignment at accept, bus error or timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= EXC_LD_MISALIGN;
            r_exc_addr  <= 32'd0;
        end else begin
            r_exc_valid <= w_misalign_acc | w_timeout | w_resp_err;
            if (w_misalign_acc) begin
                r_exc_cause <= misalign_cause(lsu_we_i);
                r_exc_addr  <= lsu_addr_i;
            end else if (w_timeout || w_resp_err) begin
                r_exc_cause <= fault_cause(r_we);
                r_exc_addr  <= r_addr;
            end
        end
    end

    assign wb_valid_o  = r_wb_valid;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign exc_valid_o = r_exc_valid;
    assign exc_cause_o = r_exc_cause;
    assign exc_addr_o  = r_exc_addr;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Bench for kamus_lsu_ctrl: directed accesses, a per-cycle expectation table
// filled from the access rules, and a compare process checking it each cycle.
module tb_kamus_lsu_ctrl;

    localparam int TO = 8;
    localparam int NC = 512;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_width_i = 2'b00;
    logic        lsu_unsigned_i = 1'b0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_wdata_i = 32'd0;
    logic [4:0]  lsu_rd_i = 5'd0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;
    logic        data_err_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic [1:0]  exc_cause_o;
    logic [31:0] exc_addr_o;
    logic        busy_o;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    bit        e_req  [NC];
    bit [31:0] e_addr [NC];
    bit [3:0]  e_be   [NC];
    bit [31:0] e_wd   [NC];
    bit        e_we   [NC];
    bit        e_busy [NC];
    bit        e_wb   [NC];
    bit [4:0]  e_wbrd [NC];
    bit [31:0] e_wbd  [NC];
    bit        e_exc  [NC];
    bit [1:0]  e_cause[NC];
    bit [31:0] e_eaddr[NC];

    bit [3:0]  s_be;
    bit [31:0] s_addr;
    bit [31:0] s_wd;
    bit        s_we;

    kamus_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_we_i       (lsu_we_i),
        .lsu_width_i    (lsu_width_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_rd_i       (lsu_rd_i),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i),
        .data_err_i     (data_err_i),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .exc_valid_o    (exc_valid_o),
        .exc_cause_o    (exc_cause_o),
        .exc_addr_o     (exc_addr_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes.
    function automatic int m_size(input bit [1:0] w);
        if (w == 2'b00) return 1;
        if (w == 2'b01) return 2;
        return 4;
    endfunction

    // Byte lanes covered by the access.
    function automatic bit [3:0] m_be(input bit [1:0] w, input bit [31:0] a);
        bit [3:0] be;
        int off;
        int sz;
        be = 4'd0;
        off = int'(a & 32'd3);
        sz = m_size(w);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    // Each lane carries the store byte that would land there for any offset.
    function automatic bit [31:0] m_lanes(input bit [1:0] w, input bit [31:0] wd);
        bit [31:0] o;
        int sz;
        o = 32'd0;
        sz = m_size(w);
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % sz) +: 8];
        return o;
    endfunction

    // Loaded value after selection and extension.
    function automatic bit [31:0] m_load(input bit [1:0] w, input bit u, input bit [31:0] a, input bit [31:0] r);
        bit [31:0] v;
        int sz;
        sz = m_size(w);
        v = r >> (8 * int'(a & 32'd3));
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic junk(input bit u);
        lsu_valid_i    = 1'b0;
        lsu_addr_i     = 32'hDEAD_BEEF;
        lsu_wdata_i    = 32'hFFFF_FFFF;
        lsu_width_i    = 2'b11;
        lsu_we_i       = ~lsu_we_i;
        lsu_rd_i       = 5'h1F;
        lsu_unsigned_i = ~u;
    endtask

    // One access starting in the current cycle. gd: grant delay (-1 = never),
    // rvd: cycles in WAIT before rvalid. Returns in the pulse cycle.
    task automatic txn(input bit we, input bit [1:0] w, input bit u, input bit [31:0] a,
                       input bit [31:0] wd, input bit [4:0] rd, input int gd, input int rvd,
                       input bit [31:0] rdat, input bit err, input bit rv_at_gnt);
        int c;
        int sz;
        int lastb;
        int pulse;
        int reqend;
        int rvk;
        bit to;
        c = cyc;
        sz = m_size(w);
        lsu_valid_i    = 1'b1;
        lsu_we_i       = we;
        lsu_width_i    = w;
        lsu_unsigned_i = u;
        lsu_addr_i     = a;
        lsu_wdata_i    = wd;
        lsu_rd_i       = rd;
        if ((a & 32'(sz - 1)) != 32'd0) begin
            e_exc[c+1]   = 1'b1;
            e_cause[c+1] = we ? 2'd1 : 2'd0;
            e_eaddr[c+1] = a;
            step();
            junk(u);
        end else begin
            to     = (gd < 0) || (gd + rvd + 2 >= TO);
            lastb  = to ? c + TO : c + 2 + gd + rvd;
            pulse  = lastb + 1;
            reqend = (gd < 0 || c + 1 + gd > lastb) ? lastb : c + 1 + gd;
            rvk    = c + 2 + gd + rvd;
            for (int k = c + 1; k <= lastb; k++) e_busy[k] = 1'b1;
            for (int k = c + 1; k <= reqend; k++) begin
                e_req[k]  = 1'b1;
                e_addr[k] = a & 32'hFFFF_FFFC;
                e_be[k]   = m_be(w, a);
                e_wd[k]   = m_lanes(w, wd);
                e_we[k]   = we;
            end
            if (to || err) begin
                e_exc[pulse]   = 1'b1;
                e_cause[pulse] = we ? 2'd3 : 2'd2;
                e_eaddr[pulse] = a;
            end else if (!we) begin
                e_wb[pulse]   = 1'b1;
                e_wbrd[pulse] = rd;
                e_wbd[pulse]  = m_load(w, u, a, rdat);
            end
            for (int k = c + 1; k <= pulse; k++) begin
                step();
                if (k == c + 1) junk(u);
                data_gnt_i    = (gd >= 0) && (k == c + 1 + gd);
                data_rvalid_i = (gd >= 0) && ((k == rvk) || (rv_at_gnt && k == c + 1 + gd));
                data_rdata_i  = (data_rvalid_i && k == rvk) ? rdat : 32'h0BAD_F00D;
                data_err_i    = data_rvalid_i && ((k == rvk) ? err : 1'b1);
                if (k == c + 1) begin
                    s_be   = data_be_o;
                    s_addr = data_addr_o;
                    s_wd   = data_wdata_o;
                    s_we   = data_we_o;
                end
            end
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            chk("req", 32'(data_req_o), 32'(e_req[cyc]));
            if (e_req[cyc]) begin
                chk("req_addr", data_addr_o, e_addr[cyc]);
                chk("req_be", 32'(data_be_o), 32'(e_be[cyc]));
                chk("req_we", 32'(data_we_o), 32'(e_we[cyc]));
                if (e_we[cyc]) chk("req_wdata", data_wdata_o, e_wd[cyc]);
            end
            chk("busy", 32'(busy_o), 32'(e_busy[cyc]));
            chk("ready", 32'(lsu_ready_o), 32'(!e_busy[cyc]));
            chk("wb_valid", 32'(wb_valid_o), 32'(e_wb[cyc]));
            if (e_wb[cyc]) begin
                chk("wb_rd", 32'(wb_rd_o), 32'(e_wbrd[cyc]));
                chk("wb_data", wb_data_o, e_wbd[cyc]);
            end
            chk("exc_valid", 32'(exc_valid_o), 32'(e_exc[cyc]));
            if (e_exc[cyc]) begin
                chk("exc_cause", 32'(exc_cause_o), 32'(e_cause[cyc]));
                chk("exc_addr", exc_addr_o, e_eaddr[cyc]);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(lsu_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_req"}, 32'(data_req_o), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_exc_valid"}, 32'(exc_valid_o), 32'd0);
        chk({tag, "_addr"}, data_addr_o, 32'd0);
        chk({tag, "_be"}, 32'(data_be_o), 32'd0);
        chk({tag, "_wdata"}, data_wdata_o, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        chk({tag, "_wb_data"}, wb_data_o, 32'd0);
        chk({tag, "_exc_addr"}, exc_addr_o, 32'd0);
    endtask

    initial begin
        int c;
        repeat (3) step();
        chk_reset_vals("rst");
        rst_ni = 1'b1;
        chk_en = 1'b1;
        step();

        // LB / LBU at offset 3 with earliest grant and response.
        txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 5'd5, 0, 0, 32'h80AA_BBCC, 1'b0, 1'b0);
        chk("lb_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
        chk("lb_be", 32'(s_be), 32'h8);
        chk("lb_addr", s_addr, 32'h0000_1000);
        txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 5'd6, 0, 0, 32'h80AA_BBCC, 1'b0, 1'b0);
        chk("lbu_wb_data", wb_data_o, 32'h0000_0080);

        // SH with a slow grant.
        txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_5678, 5'd0, 4, 0, 32'd0, 1'b0, 1'b0);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wd, 32'h5678_5678);
        chk("sh_we", 32'(s_we), 32'd1);
        chk("sh_no_wb", 32'(wb_valid_o), 32'd0);

        // Misaligned accesses never reach the port.
        txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 1'b0);
        chk("lw_mis_exc", 32'(exc_valid_o), 32'd1);
        chk("lw_mis_cause", 32'(exc_cause_o), 32'd0);
        chk("lw_mis_addr", exc_addr_o, 32'h0000_3001);
        chk("lw_mis_noreq", 32'(data_req_o), 32'd0);
        txn(1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 1'b0);
        chk("sw_mis_cause", 32'(exc_cause_o), 32'd1);
        txn(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 1'b0);
        txn(1'b0, 2'b11, 1'b0, 32'h0000_4002, 32'd0, 5'd1, 0, 0, 32'd0, 1'b0, 1'b0);

        // Halfword and word loads, byte store.
        txn(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 5'd7, 0, 0, 32'h8001_1234, 1'b0, 1'b0);
        chk("lh_wb_data", wb_data_o, 32'hFFFF_8001);
        txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 5'd8, 0, 1, 32'h8001_1234, 1'b0, 1'b0);
        chk("lhu_wb_data", wb_data_o, 32'h0000_8001);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 5'd9, 1, 2, 32'hCAFE_BABE, 1'b0, 1'b0);
        chk("lw_wb_data", wb_data_o, 32'hCAFE_BABE);
        txn(1'b0, 2'b11, 1'b0, 32'h0000_400C, 32'd0, 5'd10, 0, 0, 32'h1122_3344, 1'b0, 1'b0);
        txn(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00AB, 5'd0, 0, 0, 32'd0, 1'b0, 1'b0);
        chk("sb_be", 32'(s_be), 32'h2);
        chk("sb_wdata", s_wd, 32'hABAB_ABAB);

        // Bus errors.
        txn(1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'd0, 5'd11, 0, 0, 32'h5555_5555, 1'b1, 1'b0);
        chk("ld_fault_cause", 32'(exc_cause_o), 32'd2);
        chk("ld_fault_addr", exc_addr_o, 32'h0000_4004);
        chk("ld_fault_no_wb", 32'(wb_valid_o), 32'd0);
        txn(1'b1, 2'b10, 1'b0, 32'h0000_4008, 32'h0F0F_0F0F, 5'd0, 1, 0, 32'd0, 1'b1, 1'b0);
        chk("st_fault_cause", 32'(exc_cause_o), 32'd3);

        // rvalid during the grant cycle is not a response.
        txn(1'b1, 2'b10, 1'b0, 32'h0000_4010, 32'hA5A5_5A5A, 5'd0, 2, 1, 32'd0, 1'b0, 1'b1);
        chk("gnt_rv_no_exc", 32'(exc_valid_o), 32'd0);

        // Timeout with grant withheld, then a stray response in IDLE.
        c = cyc;
        txn(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'd0, 5'd12, -1, 0, 32'd0, 1'b0, 1'b0);
        chk("to_latency_exc", 32'(exc_valid_o), 32'd1);
        chk("to_cause", 32'(exc_cause_o), 32'd2);
        chk("to_addr", exc_addr_o, 32'h0000_6000);
        chk("to_cycles", 32'(cyc - c), 32'(TO + 1));
        step();
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        data_rdata_i  = 32'h7777_7777;
        step();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        chk("stray_rv_no_exc", 32'(exc_valid_o), 32'd0);
        chk("stray_rv_no_wb", 32'(wb_valid_o), 32'd0);
        step();

        // Response one cycle before the limit, then coincident with it.
        txn(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'd0, 5'd13, 0, 5, 32'h1357_9BDF, 1'b0, 1'b0);
        chk("late_rv_wb", 32'(wb_valid_o), 32'd1);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_6008, 32'd0, 5'd14, 0, 6, 32'h2468_ACE0, 1'b0, 1'b0);
        chk("to_beats_rv_exc", 32'(exc_valid_o), 32'd1);
        chk("to_beats_rv_no_wb", 32'(wb_valid_o), 32'd0);

        // Reset while waiting for the response.
        c = cyc;
        lsu_valid_i = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_width_i = 2'b10;
        lsu_addr_i  = 32'h0000_7000;
        lsu_wdata_i = 32'd0;
        lsu_rd_i    = 5'd3;
        e_busy[c+1] = 1'b1;
        e_busy[c+2] = 1'b1;
        e_req[c+1]  = 1'b1;
        e_addr[c+1] = 32'h0000_7000;
        e_be[c+1]   = 4'hF;
        e_we[c+1]   = 1'b0;
        step();
        junk(1'b0);
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        rst_ni = 1'b0;
        step();
        chk_reset_vals("midrst");
        rst_ni = 1'b1;
        step();

        // Normal operation after the abandoned access.
        txn(1'b0, 2'b00, 1'b0, 32'h0000_8001, 32'd0, 5'd15, 0, 0, 32'h0000_7F00, 1'b0, 1'b0);
        chk("post_rst_wb_data", wb_data_o, 32'h0000_007F);
        repeat (3) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
